// File: rtl/delay_pkg.sv
// Shared types, default widths and the dry/wet mix for the SRAM delay line.
package delay_pkg;

  localparam int ADDR_W_DEF   = 20;
  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_LATCH,
    WR,
    WR_HOLD,
    OUT
  } state_t;

  // Halving both inputs first keeps the sum inside the sample range.
  function automatic logic signed [31:0] mix(
    input logic signed [31:0] dry,
    input logic signed [31:0] wet
  );
    return (dry >>> 1) + (wet >>> 1);
  endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Sample stream interface: dry samples in, mixed samples and status out.
import delay_pkg::*;

interface delay_line_ctrl_if #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic [ADDR_W-1:0]          delay_len;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_out_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output sample_valid, sample_in, delay_len,
    input  sample_out, sample_out_valid, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_in, delay_len,
    output sample_out, sample_out_valid, busy, overrun
  );
endinterface

// File: rtl/delay_line_ctrl_sram_port.sv
// Registered async-SRAM control pins and the tri-state data driver.
import delay_pkg::*;

module sram_port #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic                drv_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [SAMPLE_W-1:0] SRAM_DQ,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  logic              oe_n_q;
  logic              we_n_q;
  logic              drv_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
      drv_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      oe_n_q <= ~rd_en;
      we_n_q <= ~wr_en;
      drv_q  <= drv_en;
      addr_q <= addr;
    end
  end

  // RESET gates the strobes at once so an aborted write cannot pulse WE_N.
  assign SRAM_CE_N = RESET;
  assign SRAM_OE_N = oe_n_q | RESET;
  assign SRAM_WE_N = we_n_q | RESET;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ   = (drv_q && !RESET) ? wdata : 'z;
  assign rdata     = SRAM_DQ;

endmodule

// File: rtl/delay_line_ctrl.sv
// Audio delay line over an async SRAM: read oldest, write newest, mix 50/50.
import delay_pkg::*;

module delay_line_ctrl #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  delay_line_ctrl_if.slave    io,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [SAMPLE_W-1:0] SRAM_DQ,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  state_t                     state_q, state_d;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic signed [SAMPLE_W-1:0] delayed_q;
  logic signed [SAMPLE_W-1:0] out_q;
  logic [ADDR_W-1:0]          len_q;
  logic [ADDR_W-1:0]          fill_q;
  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]            ptr_inc;
  logic [SAMPLE_W-1:0]        rdata;
  logic                       out_vld_q;
  logic                       ovr_q;
  logic                       accept;

  assign ptr_inc = {1'b0, wr_ptr_q} + 1'b1;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.sample_valid) begin
          accept  = 1'b1;
          state_d = (io.delay_len == '0) ? OUT : RD;
          if (io.delay_len <= wr_ptr_q) wr_ptr_d = '0;
        end
      end
      RD:       state_d = RD_LATCH;
      RD_LATCH: state_d = WR;
      WR:       state_d = WR_HOLD;
      WR_HOLD:  state_d = OUT;
      OUT: begin
        state_d  = IDLE;
        wr_ptr_d = (ptr_inc >= {1'b0, len_q}) ? '0 : ptr_inc[ADDR_W-1:0];
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      len_q     <= '0;
      sample_q  <= '0;
      delayed_q <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      out_vld_q <= (state_q == OUT);
      if (accept) begin
        sample_q <= io.sample_in;
        len_q    <= io.delay_len;
        if (io.delay_len != len_q) fill_q <= '0;
      end
      if (state_q != IDLE && io.sample_valid) ovr_q <= 1'b1;
      if (state_q == RD_LATCH)
        delayed_q <= (fill_q >= len_q) ? rdata : '0;
      if (state_q == WR_HOLD && fill_q < len_q)
        fill_q <= fill_q + 1'b1;
      if (state_q == OUT)
        out_q <= (len_q == '0) ? sample_q :
          SAMPLE_W'(mix(32'(sample_q), 32'(delayed_q)));
    end
  end

  assign io.sample_out       = out_q;
  assign io.sample_out_valid = out_vld_q;
  assign io.busy             = (state_q != IDLE);
  assign io.overrun          = ovr_q;

  sram_port #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) u_sram (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_en     (state_d == RD || state_d == RD_LATCH),
    .wr_en     (state_d == WR),
    .drv_en    (state_d == WR || state_d == WR_HOLD),
    .addr      (wr_ptr_d),
    .wdata     (sample_q),
    .rdata     (rdata),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a behavioural async SRAM.
import delay_pkg::*;

module tb_delay_line_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  delay_line_ctrl_if #(.ADDR_W(20), .SAMPLE_W(16)) io ();

  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  delay_line_ctrl #(.ADDR_W(20), .SAMPLE_W(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .io        (io),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  logic [15:0] mem [0:255];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N)
                   ? mem[SRAM_ADDR[7:0]] : 'z;
  always @(posedge CLK)
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;

  typedef struct {
    bit                 rst;
    logic signed [15:0] din;
    logic [19:0]        len;
    logic signed [15:0] dout;
    int                 addr;
    int                 lat;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic add(input bit r, input int din, input int len,
                     input int dout, input int addr, input int lat);
    vec_t v;
    v.rst  = r;
    v.din  = 16'(din);
    v.len  = 20'(len);
    v.dout = 16'(dout);
    v.addr = addr;
    v.lat  = lat;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    io.sample_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  // Accepts one sample and waits (bounded) for its output strobe.
  task automatic send(input logic signed [15:0] din, input logic [19:0] len,
                      output int lat, output int wa, output bit rd);
    lat = -1;
    wa  = -1;
    rd  = 1'b0;
    io.sample_valid = 1'b1;
    io.sample_in    = din;
    io.delay_len    = len;
    @(posedge CLK);
    #1;
    io.sample_valid = 1'b0;
    io.sample_in    = 16'sh5a5a;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK);
      #1;
      if (!SRAM_WE_N) wa = int'(SRAM_ADDR);
      if (!SRAM_OE_N) rd = 1'b1;
      if (io.sample_out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  int lat, wa, nv;
  bit rd;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1234;
    io.sample_valid = 1'b0;
    io.sample_in    = '0;
    io.delay_len    = 20'd4;

    // Fixed-delay run with delay 4.
    add(1, 100, 4, 50, 0, 5);
    add(0, 200, 4, 100, 1, 5);
    add(0, 300, 4, 150, 2, 5);
    add(0, 400, 4, 200, 3, 5);
    add(0, 500, 4, 300, 0, 5);
    add(0, 600, 4, 400, 1, 5);
    // Pointer wrap at delay 3.
    add(1, 1000, 3, 500, 0, 5);
    add(0, 1000, 3, 500, 1, 5);
    add(0, 1000, 3, 500, 2, 5);
    add(0, 1000, 3, 1000, 0, 5);
    add(0, 1000, 3, 1000, 1, 5);
    add(0, 1000, 3, 1000, 2, 5);
    add(0, 1000, 3, 1000, 0, 5);
    // Shrink to 1 forces pointer to 0; full-scale negatives.
    add(0, -32768, 1, -16384, 0, 5);
    add(0, -32768, 1, -32768, 0, 5);
    // Bypass.
    add(0, -32768, 0, -32768, -1, 1);
    add(0, 101, 0, 101, -1, 1);
    // Delay 2 with signed rounding.
    add(0, -3, 2, -2, 0, 5);
    add(0, 7, 2, 3, 1, 5);
    add(0, 9, 2, 2, 0, 5);

    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("ce_n_in_reset", int'(SRAM_CE_N), 1);
    chk("oe_n_in_reset", int'(SRAM_OE_N), 1);
    RESET = 1'b0;
    #1;
    chk("rst_busy", int'(io.busy), 0);
    chk("rst_overrun", int'(io.overrun), 0);
    chk("rst_out", int'(io.sample_out), 0);
    chk("rst_valid", int'(io.sample_out_valid), 0);
    chk("rst_we_n", int'(SRAM_WE_N), 1);
    chk("ce_n_run", int'(SRAM_CE_N), 0);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      send(vq[i].din, vq[i].len, lat, wa, rd);
      chk($sformatf("v%0d_lat", i), lat, vq[i].lat);
      chk($sformatf("v%0d_out", i), int'(io.sample_out), int'(vq[i].dout));
      chk($sformatf("v%0d_addr", i), wa, vq[i].addr);
      if (vq[i].addr < 0) chk($sformatf("v%0d_rd", i), int'(rd), 0);
    end
    chk("no_overrun_seq", int'(io.overrun), 0);

    // Second strobe while busy is dropped.
    do_reset();
    io.delay_len    = 20'd4;
    io.sample_in    = 16'sd40;
    io.sample_valid = 1'b1;
    @(posedge CLK);
    #1 io.sample_valid = 1'b0;
    @(posedge CLK);
    #1 io.sample_valid = 1'b1;
    io.sample_in = 16'sd80;
    chk("busy_mid", int'(io.busy), 1);
    @(posedge CLK);
    #1 io.sample_valid = 1'b0;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK);
      #1 if (io.sample_out_valid) nv++;
    end
    chk("ovr_valids", nv, 1);
    chk("ovr_flag", int'(io.overrun), 1);
    chk("ovr_out", int'(io.sample_out), 20);

    // New sample on the cycle the FSM returns to IDLE.
    do_reset();
    send(16'sd10, 20'd0, lat, wa, rd);
    chk("b2b_first", int'(io.sample_out), 10);
    send(16'sd20, 20'd0, lat, wa, rd);
    chk("b2b_lat", lat, 1);
    chk("b2b_second", int'(io.sample_out), 20);
    chk("b2b_overrun", int'(io.overrun), 0);

    // Reset in the middle of a write.
    send(16'sd77, 20'd0, lat, wa, rd);
    chk("pre_abort_out", int'(io.sample_out), 77);
    io.sample_valid = 1'b1;
    io.sample_in    = 16'sd500;
    io.delay_len    = 20'd4;
    @(posedge CLK);
    #1 io.sample_valid = 1'b0;
    nv = 0;
    while (SRAM_WE_N && nv < 10) begin
      @(posedge CLK);
      #1 nv++;
    end
    chk("abort_reached_wr", int'(SRAM_WE_N), 0);
    RESET = 1'b1;
    #1;
    chk("abort_we_n_now", int'(SRAM_WE_N), 1);
    @(posedge CLK);
    #1;
    chk("abort_we_n", int'(SRAM_WE_N), 1);
    chk("abort_oe_n", int'(SRAM_OE_N), 1);
    chk("abort_ce_n", int'(SRAM_CE_N), 1);
    chk("abort_busy", int'(io.busy), 0);
    chk("abort_out", int'(io.sample_out), 0);
    RESET = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK);
      #1 if (!SRAM_WE_N || !SRAM_OE_N) nv++;
    end
    chk("abort_quiet", nv, 0);
    chk("abort_idle", int'(io.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
